// File: rtl/mac_result_buffer.sv
// Result buffer behind a fixed-latency MAC: credit-based launch control plus a
// first-word fall-through FIFO. Optional sticky error flag under RESBUF_ERR_DETECT_EN.
module mac_result_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          issue_req,
  output logic          issue_grant,
  input  logic          res_valid_in,
  input  logic [DW-1:0] res_data_in,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
`ifdef RESBUF_ERR_DETECT_EN
  ,
  output logic          err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem [DEPTH];

  logic [CW:0] credit_used;
  logic        launch;
  logic        pop;
  logic        full;
  logic        push;

  // Every launched op reserves a slot, so results never arrive to a full buffer
  // in correct operation.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_grant = credit_used < (CW+1)'(DEPTH);
  assign m_valid     = (count_q != '0);
  assign m_data      = mem[rd_ptr_q];

  always_comb begin
    launch     = issue_req & issue_grant;
    pop        = m_valid & m_ready;
    full       = (count_q == CW'(DEPTH));
    push       = res_valid_in & (~full | pop);
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A stray result with nothing in flight must not wrap the counter.
    if (launch && !res_valid_in) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!launch && res_valid_in && inflight_q != '0) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= res_data_in;
  end

`ifdef RESBUF_ERR_DETECT_EN
  logic err_q, err_d;
  logic drop;
  logic stray;

  always_comb begin
    drop  = res_valid_in & full & ~pop;
    stray = res_valid_in & (inflight_q == '0);
    err_d = err_q | drop | stray;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mac_result_buffer.sv
// Scoreboard bench for mac_result_buffer: expected results queued when driven,
// compared when popped downstream.
module tb_mac_result_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          aclr;
  logic          issue_req;
  logic          issue_grant;
  logic          res_valid_in;
  logic [DW-1:0] res_data_in;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef RESBUF_ERR_DETECT_EN
  logic          err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  mac_result_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .aclr         (aclr),
    .issue_req    (issue_req),
    .issue_grant  (issue_grant),
    .res_valid_in (res_valid_in),
    .res_data_in  (res_data_in),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready)
`ifdef RESBUF_ERR_DETECT_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_result(input logic [DW-1:0] d, input bit expect_stored);
    res_valid_in = 1'b1;
    res_data_in  = d;
    if (expect_stored) exp_q.push_back(d);
    tick();
    res_valid_in = 1'b0;
  endtask

  // Inputs are stable from posedge+1 until the next edge, so negedge sees what the
  // DUT will sample.
  always @(negedge clk) begin
    if (!aclr && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pop", 64'(m_valid), 64'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("[TB] pop data=0x%08h expected=0x%08h", m_data, e);
        check_val("m_data", 64'(m_data), 64'(e));
      end
    end
  end

  initial begin
    int launches;
    int launched;
    int received;
    int due_q[$];
    int data_q[$];

    aclr         = 1'b1;
    issue_req    = 1'b0;
    res_valid_in = 1'b0;
    res_data_in  = '0;
    m_ready      = 1'b1;
    repeat (3) tick();

    // Reset state
    check_val("rst_grant", 64'(issue_grant), 64'd1);
    check_val("rst_valid", 64'(m_valid), 64'd0);
`ifdef RESBUF_ERR_DETECT_EN
    check_val("rst_err", 64'(err), 64'd0);
`endif
    aclr = 1'b0;
    tick();

    // Single operation, 7-cycle latency, no bypass
    issue_req = 1'b1;
    check_val("single_grant", 64'(issue_grant), 64'd1);
    tick();
    issue_req = 1'b0;
    repeat (6) tick();
    res_valid_in = 1'b1;
    res_data_in  = 32'h0000_1234;
    exp_q.push_back(32'h0000_1234);
    check_val("no_bypass", 64'(m_valid), 64'd0);
    tick();
    res_valid_in = 1'b0;
    check_val("single_valid", 64'(m_valid), 64'd1);
    tick();
    check_val("single_drained", 64'(m_valid), 64'd0);
`ifdef RESBUF_ERR_DETECT_EN
    check_val("err_clean", 64'(err), 64'd0);
`endif

    // Credit limit with downstream stalled
    m_ready   = 1'b0;
    issue_req = 1'b1;
    launches  = 0;
    for (int i = 0; i < 12; i++) begin
      if (issue_grant) launches++;
      tick();
    end
    issue_req = 1'b0;
    check_val("credit_launches", 64'(launches), 64'(DEPTH));
    check_val("credit_grant_lo", 64'(issue_grant), 64'd0);
    for (int i = 0; i < DEPTH; i++) drive_result(32'(100 + i), 1'b1);
    check_val("full_grant_lo", 64'(issue_grant), 64'd0);
    check_val("full_valid", 64'(m_valid), 64'd1);

    // Push and pop together at full: count stays at DEPTH
    m_ready = 1'b1;
    drive_result(32'h0000_00AA, 1'b1);
    m_ready = 1'b0;
    check_val("full_pushpop_grant", 64'(issue_grant), 64'd0);
`ifdef RESBUF_ERR_DETECT_EN
    check_val("err_stray", 64'(err), 64'd1);
`endif

    // Push at full without pop is dropped
    drive_result(32'h0000_00BB, 1'b0);
    check_val("drop_grant", 64'(issue_grant), 64'd0);

    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_val("pop_regrant", 64'(issue_grant), 64'd1);
    m_ready = 1'b1;
    repeat (10) tick();
    check_val("drain_valid", 64'(m_valid), 64'd0);
    check_val("drain_queue", 64'(exp_q.size()), 64'd0);
    check_val("drain_grant", 64'(issue_grant), 64'd1);

    // Ordering and pointer wrap with continuous launch
    launched = 0;
    received = 0;
    for (int cyc = 0; cyc < 300 && received < 20; cyc++) begin
      res_valid_in = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        res_valid_in = 1'b1;
        res_data_in  = 32'(data_q.pop_front());
        void'(due_q.pop_front());
        exp_q.push_back(res_data_in);
        received++;
      end
      issue_req = (launched < 20);
      if (issue_req && issue_grant) begin
        due_q.push_back(cyc + 7);
        data_q.push_back(launched);
        launched++;
      end
      tick();
    end
    res_valid_in = 1'b0;
    issue_req    = 1'b0;
    repeat (4) tick();
    check_val("order_received", 64'(received), 64'd20);
    check_val("order_queue", 64'(exp_q.size()), 64'd0);
    check_val("order_valid", 64'(m_valid), 64'd0);
`ifdef RESBUF_ERR_DETECT_EN
    check_val("err_sticky", 64'(err), 64'd1);
`endif

    // Mid-operation asynchronous reset: 3 buffered, 2 in flight
    m_ready   = 1'b0;
    issue_req = 1'b1;
    repeat (5) tick();
    issue_req = 1'b0;
    for (int i = 0; i < 3; i++) drive_result(32'(200 + i), 1'b1);
    check_val("pre_rst_valid", 64'(m_valid), 64'd1);
    #2;
    aclr = 1'b1;
    #1;
    check_val("async_rst_valid", 64'(m_valid), 64'd0);
    check_val("async_rst_grant", 64'(issue_grant), 64'd1);
`ifdef RESBUF_ERR_DETECT_EN
    check_val("async_rst_err", 64'(err), 64'd0);
`endif
    exp_q.delete();
    tick();
    aclr    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("post_rst_valid", 64'(m_valid), 64'd0);
    end
    check_val("post_rst_grant", 64'(issue_grant), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_result_buffer.md
MAC_RESULT_BUFFER -- requirements
Module: mac_result_buffer

Interface
- REQ-001 SHALL have parameter DW, default 32, result data width in bits.
- REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, at least 2.
- REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge active.
- REQ-004 SHALL have port aclr, input, 1 bit: reset, asynchronous, active-high.
- REQ-005 SHALL have port issue_req, input, 1 bit: upstream requests to launch one MAC operation.
- REQ-006 SHALL have port issue_grant, output, 1 bit: launch permitted this cycle.
- REQ-007 SHALL have port res_valid_in, input, 1 bit: MAC valid-pipeline output; result present this cycle.
- REQ-008 SHALL have port res_data_in, input, DW bits: MAC result, sampled when res_valid_in=1.
- REQ-009 SHALL have port m_valid, output, 1 bit: buffered result available downstream.
- REQ-010 SHALL have port m_data, output, DW bits: oldest buffered result.
- REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts m_data.
- REQ-012 SHALL have port err, output, 1 bit: sticky error flag, present only under RESBUF_ERR_DETECT_EN.

Function
- REQ-013 SHALL keep a count register (0..DEPTH) of buffered entries and an inflight register (0..DEPTH) of launched operations whose result has not yet arrived.
- REQ-014 SHALL drive issue_grant = 1 when (count + inflight) < DEPTH, computed combinationally from registers only; it SHALL NOT depend on issue_req.
- REQ-015 SHALL treat issue_req & issue_grant as an accepted launch; inflight +1 on an accepted launch, -1 on res_valid_in, unchanged when both occur in the same cycle.
- REQ-016 SHALL hold inflight at 0 when res_valid_in arrives with inflight = 0 (no wrap).
- REQ-017 SHALL push res_data_in on every res_valid_in; the MAC pipeline cannot stall, so results are never back-pressured.
- REQ-018 SHALL pop when m_valid & m_ready.
- REQ-019 SHALL drive m_valid = (count != 0) and m_data = mem[rd_ptr] (first-word fall-through from registered storage).
- REQ-020 SHALL have no bypass: a push into an empty buffer appears on m_valid the following cycle.
- REQ-021 SHALL accept a push at count = DEPTH when a pop occurs in the same cycle; count is then unchanged.
- REQ-022 SHALL drop a push at count = DEPTH when no pop occurs in the same cycle; storage and pointers are unchanged.
- REQ-023 SHALL wrap wr_ptr and rd_ptr modulo DEPTH, each log2(DEPTH) bits.
- REQ-024 SHALL leave m_data undefined-but-stable while m_valid = 0; the bench SHALL NOT check it then.

Reset
- REQ-025 SHALL, while aclr = 1, asynchronously force count = 0, inflight = 0, wr_ptr = 0, rd_ptr = 0 and err = 0, giving issue_grant = 1 and m_valid = 0.
- REQ-026 SHALL discard all buffered and in-flight results on aclr asserted mid-operation; the MAC valid pipeline shares aclr, so no stale result arrives afterwards.
- REQ-027 SHALL NOT reset the storage array.

Configuration
- REQ-028 With macro RESBUF_ERR_DETECT_EN defined, err SHALL be set on the edge after a dropped push (REQ-022) or a result arriving with inflight = 0 (REQ-016), and SHALL stay set until aclr.
- REQ-029 Without RESBUF_ERR_DETECT_EN, the err port and its logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-030 Reset then single op: issue_req for 1 cycle; res_valid_in 7 cycles later with 0x0000_1234 -> inflight 1 then 0, m_valid=1 the next cycle with m_data=0x0000_1234; pop with m_ready=1 -> m_valid=0.
- REQ-031 Credit limit: DEPTH=8, m_ready=0, issue_req held high -> exactly 8 launches granted, then issue_grant=0; after 8 results arrive, count=8 and inflight=0; one pop -> issue_grant=1 the next cycle.
- REQ-032 Ordering and wrap: push 20 results 0..19 through continuous launch with m_ready=1 -> m_data sequence 0..19 in order, no loss, pointers wrap twice.
- REQ-033 Simultaneous push and pop at full: count=8, res_valid_in=1 with 0xAA and m_ready=1 in the same cycle -> count stays 8, 0xAA is the last entry.
- REQ-034 Error with RESBUF_ERR_DETECT_EN defined: force res_valid_in=1 with inflight=0 -> err=1 the next cycle, inflight stays 0, err stays 1 until aclr.
- REQ-035 Mid-operation reset: 3 entries buffered, 2 in flight, assert aclr asynchronously -> m_valid=0, issue_grant=1 immediately; no output after aclr is released.
